// File: rtl/duty_button_conditioner.sv
// Increase/decrease duty buttons: 2-flop sync, debounce, press pulse and optional auto-repeat.
// Build option: define AUTO_REPEAT_EN to add the REPEAT state and repeat counters.

module duty_button_channel #(
    parameter int DEBOUNCE_CYCLES = 4
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_PERIOD   = 10
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic inhibit,
    output logic level,
    output logic pulse
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

`ifdef AUTO_REPEAT_EN
    localparam int RW = 16;
    typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;
    logic [RW-1:0] rpt_cnt, rpt_nx;
`else
    typedef enum logic {IDLE, HELD} state_t;
`endif

    state_t        state, state_nx;
    logic          sync1, sync2;
    logic [DW-1:0] db_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            db_cnt <= '0;
            level  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != level) begin
                if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    level  <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
`ifdef AUTO_REPEAT_EN
            rpt_cnt <= '0;
`endif
        end else begin
            state   <= state_nx;
`ifdef AUTO_REPEAT_EN
            rpt_cnt <= rpt_nx;
`endif
        end
    end

    // The press pulse is combinational from IDLE so it appears in the first high-level cycle.
    always_comb begin
        state_nx = state;
        pulse    = 1'b0;
`ifdef AUTO_REPEAT_EN
        rpt_nx   = rpt_cnt;
`endif
        if (!level || inhibit) begin
            state_nx = IDLE;
`ifdef AUTO_REPEAT_EN
            rpt_nx   = '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    pulse    = 1'b1;
                    state_nx = HELD;
`ifdef AUTO_REPEAT_EN
                    rpt_nx   = '0;
`endif
                end
                HELD: begin
`ifdef AUTO_REPEAT_EN
                    if (rpt_cnt == RW'(REPEAT_DELAY - 1)) begin
                        pulse    = 1'b1;
                        state_nx = REPEAT;
                        rpt_nx   = '0;
                    end else if (rpt_cnt != '1) begin
                        rpt_nx = rpt_cnt + 1'b1;
                    end
`else
                    state_nx = HELD;
`endif
                end
`ifdef AUTO_REPEAT_EN
                REPEAT: begin
                    if (rpt_cnt == RW'(REPEAT_PERIOD - 1)) begin
                        pulse  = 1'b1;
                        rpt_nx = '0;
                    end else if (rpt_cnt != '1) begin
                        rpt_nx = rpt_cnt + 1'b1;
                    end
                end
`endif
                default: state_nx = IDLE;
            endcase
        end
    end
endmodule

module duty_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_PERIOD   = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic increase_duty,
    input  logic decrease_duty,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic inc_level,
    output logic dec_level
);
    logic both;

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be 1..255");
    end
    if (REPEAT_DELAY < 2 || REPEAT_DELAY > 65535) begin : g_bad_delay
        $error("REPEAT_DELAY must be 2..65535");
    end
    if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > 65535) begin : g_bad_period
        $error("REPEAT_PERIOD must be 1..65535");
    end

    // Both buttons down is ambiguous: suppress pulses and hold both channels in IDLE.
    assign both = inc_level & dec_level;

    duty_button_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_inc (
        .clk    (clk),
        .reset  (reset),
        .raw    (increase_duty),
        .inhibit(both),
        .level  (inc_level),
        .pulse  (inc_pulse)
    );

    duty_button_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_dec (
        .clk    (clk),
        .reset  (reset),
        .raw    (decrease_duty),
        .inhibit(both),
        .level  (dec_level),
        .pulse  (dec_pulse)
    );
endmodule

// File: tb/tb_duty_button_conditioner.sv
// Bench for duty_button_conditioner: vector table, scripted press sequences, random run vs model.
module tb_duty_button_conditioner;
    localparam int DB = 4;
    localparam int RD = 50;
    localparam int RP = 10;

    logic clk = 1'b0;
    logic reset, increase_duty, decrease_duty;
    logic inc_pulse, dec_pulse, inc_level, dec_level;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int inc_q[$];
    int dec_q[$];
    int inc_lvl_cnt = 0;

    always #5 clk = ~clk;

    duty_button_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .increase_duty(increase_duty),
        .decrease_duty(decrease_duty),
        .inc_pulse    (inc_pulse),
        .dec_pulse    (dec_pulse),
        .inc_level    (inc_level),
        .dec_level    (dec_level)
    );

    // Reference: raw sample history (bit k = sample k edges ago), a level flips once the
    // synchronized samples seen over the last DB edges all disagree with it; pulses are
    // scheduled by the age of an uncontested press.
    logic [DB+1:0] hist_i = '0, hist_d = '0, nh_i, nh_d;
    logic m_il = 0, m_dl = 0, m_ip = 0, m_dp = 0, el_i = 0, el_d = 0;
    logic nl_i, nl_d, ne_i, ne_d, np_i, np_d;
    int age_i = 0, age_d = 0, na_i, na_d;

    function automatic logic settle(input logic [DB+1:0] h, input logic lvl);
        for (int k = 2; k <= DB + 1; k++) if (h[k] == lvl) return lvl;
        return !lvl;
    endfunction

    function automatic logic fire(input int a);
`ifdef AUTO_REPEAT_EN
        return (a == 0) || (a == RD) || (a > RD && ((a - RD) % RP) == 0);
`else
        return a == 0;
`endif
    endfunction

    always_comb begin
        nh_i = {hist_i[DB:0], increase_duty};
        nh_d = {hist_d[DB:0], decrease_duty};
        nl_i = settle(nh_i, m_il);
        nl_d = settle(nh_d, m_dl);
        ne_i = nl_i & ~nl_d;
        ne_d = nl_d & ~nl_i;
        na_i = (ne_i && el_i) ? age_i + 1 : 0;
        na_d = (ne_d && el_d) ? age_d + 1 : 0;
        np_i = ne_i && fire(na_i);
        np_d = ne_d && fire(na_d);
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_i <= '0; hist_d <= '0; m_il <= 0; m_dl <= 0; m_ip <= 0; m_dp <= 0;
            el_i <= 0; el_d <= 0; age_i <= 0; age_d <= 0;
        end else begin
            hist_i <= nh_i; hist_d <= nh_d; m_il <= nl_i; m_dl <= nl_d;
            el_i <= ne_i; el_d <= ne_d; age_i <= na_i; age_d <= na_d;
            m_ip <= np_i; m_dp <= np_d;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        chk("model inc_level", int'(inc_level), int'(m_il));
        chk("model dec_level", int'(dec_level), int'(m_dl));
        chk("model inc_pulse", int'(inc_pulse), int'(m_ip));
        chk("model dec_pulse", int'(dec_pulse), int'(m_dp));
        if (inc_pulse === 1'b1) inc_q.push_back(cyc);
        if (dec_pulse === 1'b1) dec_q.push_back(cyc);
        if (inc_level === 1'b1) inc_lvl_cnt++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    typedef struct {
        logic inc; logic dec; int n;
        logic il; logic dl; logic ip; logic dp;
    } vec_t;
    vec_t tbl[11];

    int r, r2, nb, base, ri, rd;
    int exp_off[$];

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 8, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 5, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 3, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 3, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 5, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset with the increase button already held.
        reset = 1'b1; increase_duty = 1'b1; decrease_duty = 1'b0;
        cycles(3);
        chk("reset inc_level", int'(inc_level), 0);
        chk("reset dec_level", int'(dec_level), 0);
        chk("reset inc_pulse", int'(inc_pulse), 0);
        chk("reset dec_pulse", int'(dec_pulse), 0);
        inc_q.delete();
        reset = 1'b0; r = cyc;
        cycles(12);
        chk("held-through-reset pulses", inc_q.size(), 1);
        chk("held-through-reset latency", qat(inc_q, 0), r + 6);
        increase_duty = 1'b0;
        cycles(12);

        for (int i = 0; i < 11; i++) begin
            increase_duty = tbl[i].inc; decrease_duty = tbl[i].dec;
            repeat (tbl[i].n) @(negedge clk);
            chk($sformatf("vec%0d inc_level", i), int'(inc_level), int'(tbl[i].il));
            chk($sformatf("vec%0d dec_level", i), int'(dec_level), int'(tbl[i].dl));
            chk($sformatf("vec%0d inc_pulse", i), int'(inc_pulse), int'(tbl[i].ip));
            chk($sformatf("vec%0d dec_pulse", i), int'(dec_pulse), int'(tbl[i].dp));
            #1;
        end
        cycles(4);

        // Three short presses.
        inc_q.delete(); dec_q.delete(); exp_off.delete();
        for (int k = 0; k < 3; k++) begin
            exp_off.push_back(cyc + 6);
            increase_duty = 1'b1; cycles(10);
            increase_duty = 1'b0; cycles(10);
        end
        cycles(5);
        chk("short presses count", inc_q.size(), 3);
        for (int k = 0; k < 3; k++) chk($sformatf("short press %0d time", k), qat(inc_q, k), exp_off[k]);
        chk("short presses dec count", dec_q.size(), 0);

        // Bounce shorter than the debounce window.
        inc_q.delete(); nb = inc_lvl_cnt;
        for (int k = 0; k < 8; k++) begin increase_duty = ~increase_duty; cycles(1); end
        for (int k = 0; k < 12; k++) begin increase_duty = (k % 4) != 3; cycles(1); end
        increase_duty = 1'b0; cycles(8);
        chk("bounce inc_level cycles", inc_lvl_cnt - nb, 0);
        chk("bounce inc_pulse count", inc_q.size(), 0);

        // Long hold: press pulse plus auto-repeat.
        inc_q.delete(); r = cyc;
        increase_duty = 1'b1; cycles(90);
        increase_duty = 1'b0; cycles(12);
        exp_off.delete();
`ifdef AUTO_REPEAT_EN
        exp_off = '{0, 50, 60, 70, 80};
`else
        exp_off = '{0};
`endif
        chk("long hold count", inc_q.size(), exp_off.size());
        foreach (exp_off[k]) chk($sformatf("long hold pulse %0d", k), qat(inc_q, k), r + 6 + exp_off[k]);

        // Overlap, then decrease released.
        inc_q.delete(); dec_q.delete();
        increase_duty = 1'b1; decrease_duty = 1'b1; cycles(30);
        chk("overlap inc pulses", inc_q.size(), 0);
        chk("overlap dec pulses", dec_q.size(), 0);
        decrease_duty = 1'b0; r2 = cyc; cycles(10);
        increase_duty = 1'b0; cycles(12);
        chk("after-overlap inc count", inc_q.size(), 1);
        chk("after-overlap inc time", qat(inc_q, 0), r2 + 6);
        chk("after-overlap dec count", dec_q.size(), 0);

        // Reset in the middle of a repeat.
        inc_q.delete(); r = cyc;
        increase_duty = 1'b1; cycles(60);
        reset = 1'b1; #1;
        chk("mid reset inc_level", int'(inc_level), 0);
        chk("mid reset inc_pulse", int'(inc_pulse), 0);
`ifdef AUTO_REPEAT_EN
        chk("pre-reset pulses", inc_q.size(), 2);
`else
        chk("pre-reset pulses", inc_q.size(), 1);
`endif
        base = inc_q.size();
        cycles(10);
        chk("pulses during reset", inc_q.size(), base);
        reset = 1'b0; r2 = cyc;
        cycles(20);
        chk("post-reset count", inc_q.size(), base + 1);
        chk("post-reset latency", qat(inc_q, base), r2 + 6);
        increase_duty = 1'b0; cycles(12);

        // Random run against the model.
        ri = 1; rd = 1;
        for (int c = 0; c < 4000; c++) begin
            if (ri <= 0) begin
                increase_duty = ~increase_duty;
                ri = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 130);
            end
            if (rd <= 0) begin
                decrease_duty = ~decrease_duty;
                rd = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 130);
            end
            reset = ($urandom_range(0, 599) == 0);
            cycles(1);
            ri--; rd--;
        end
        reset = 1'b0; increase_duty = 1'b0; decrease_duty = 1'b0;
        cycles(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
